// File: rtl/gray_frame_ctrl.sv
// Frame sequencer ahead of the grayscale stage: drains the input FIFO, sends the
// first hdr_len words to the header FIFO and the next width*height words to the pixel FIFO.
module gray_frame_ctrl #(
  parameter int DWIDTH = 24,
  parameter int CWIDTH = 16,
  parameter int HWIDTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CWIDTH-1:0] width,
  input  logic [CWIDTH-1:0] height,
  input  logic [HWIDTH-1:0] hdr_len,
  output logic              busy,
  output logic              done,
  output logic              fifo_in_rd_en,
  input  logic [DWIDTH-1:0] fifo_in_dout,
  input  logic              fifo_in_empty,
  output logic              hdr_wr_en,
  output logic [DWIDTH-1:0] hdr_din,
  input  logic              hdr_full,
  output logic              pix_wr_en,
  output logic [DWIDTH-1:0] pix_din,
  input  logic              pix_full,
  output logic [CWIDTH-1:0] col,
  output logic [CWIDTH-1:0] row,
  output logic              pix_last
);

  typedef enum logic [1:0] {IDLE, HEADER, PIXELS, DONE} state_e;

  state_e            state_q;
  logic [CWIDTH-1:0] width_q;
  logic [CWIDTH-1:0] height_q;
  logic [HWIDTH-1:0] hdr_len_q;
  logic [HWIDTH-1:0] hdr_cnt_q;
  logic [CWIDTH-1:0] col_q;
  logic [CWIDTH-1:0] row_q;

  logic col_end;
  logic row_end;
  logic hdr_end;
  logic hdr_xfer;
  logic pix_xfer;

  // Compares only ever see the latched geometry, so mid-frame input changes are harmless.
  assign col_end  = (col_q == width_q - CWIDTH'(1));
  assign row_end  = (row_q == height_q - CWIDTH'(1));
  assign hdr_end  = (hdr_cnt_q == hdr_len_q - HWIDTH'(1));
  assign hdr_xfer = (state_q == HEADER) && !fifo_in_empty && !hdr_full;
  assign pix_xfer = (state_q == PIXELS) && !fifo_in_empty && !pix_full;

  assign fifo_in_rd_en = hdr_xfer || pix_xfer;
  assign hdr_wr_en     = hdr_xfer;
  assign pix_wr_en     = pix_xfer;
  assign hdr_din       = fifo_in_dout;
  assign pix_din       = fifo_in_dout;
  assign busy          = (state_q == HEADER) || (state_q == PIXELS);
  assign done          = (state_q == DONE);
  assign col           = col_q;
  assign row           = row_q;
  assign pix_last      = (state_q == PIXELS) && col_end && row_end;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      width_q   <= '0;
      height_q  <= '0;
      hdr_len_q <= '0;
      hdr_cnt_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            width_q   <= width;
            height_q  <= height;
            hdr_len_q <= hdr_len;
            hdr_cnt_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
            if (width == '0 || height == '0) begin
              state_q <= DONE;
            end else if (hdr_len != '0) begin
              state_q <= HEADER;
            end else begin
              state_q <= PIXELS;
            end
          end
        end
        HEADER: begin
          if (hdr_xfer) begin
            hdr_cnt_q <= hdr_cnt_q + HWIDTH'(1);
            if (hdr_end) begin
              state_q <= PIXELS;
            end
          end
        end
        PIXELS: begin
          // The final pixel leaves col/row on its own position rather than wrapping.
          if (pix_xfer) begin
            if (col_end && row_end) begin
              state_q <= DONE;
            end else if (col_end) begin
              col_q <= '0;
              row_q <= row_q + CWIDTH'(1);
            end else begin
              col_q <= col_q + CWIDTH'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_frame_ctrl.sv
// Self-checking bench for gray_frame_ctrl: frame table plus randomized frames,
// compared cycle by cycle against a word-count model of the frame stream.
module tb_gray_frame_ctrl;
  localparam int DW = 24;
  localparam int CW = 16;
  localparam int HW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] width = '0;
  logic [CW-1:0] height = '0;
  logic [HW-1:0] hdr_len = '0;
  logic          busy;
  logic          done;
  logic          fifo_in_rd_en;
  logic [DW-1:0] fifo_in_dout = '0;
  logic          fifo_in_empty = 1'b1;
  logic          hdr_wr_en;
  logic [DW-1:0] hdr_din;
  logic          hdr_full = 1'b0;
  logic          pix_wr_en;
  logic [DW-1:0] pix_din;
  logic          pix_full = 1'b0;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic          pix_last;

  always #5 clock = ~clock;

  gray_frame_ctrl #(.DWIDTH(DW), .CWIDTH(CW), .HWIDTH(HW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .width(width), .height(height), .hdr_len(hdr_len),
    .busy(busy), .done(done), .fifo_in_rd_en(fifo_in_rd_en),
    .fifo_in_dout(fifo_in_dout), .fifo_in_empty(fifo_in_empty),
    .hdr_wr_en(hdr_wr_en), .hdr_din(hdr_din), .hdr_full(hdr_full),
    .pix_wr_en(pix_wr_en), .pix_din(pix_din), .pix_full(pix_full),
    .col(col), .row(row), .pix_last(pix_last)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame is a word stream; the first m_hl words are header,
  // the remaining m_w*m_h are pixels, position derived from the pixel index.
  logic [DW-1:0] in_q[$];
  bit m_active = 0;
  bit m_done_now = 0;
  bit m_xfer = 0;
  int m_hl = 0, m_w = 0, m_h = 0, m_n = 0, m_total = 0;
  int m_col_hold = 0, m_row_hold = 0;
  int cnt_hdr, cnt_pix, cnt_done, cnt_rd;
  int stall_mode;
  bit noisy;

  task automatic drive_cycle(input int rel);
    bit e, hf, pf;
    e = 0; hf = 0; pf = 0;
    case (stall_mode)
      1: begin
        e  = ($urandom % 3) == 0;
        hf = ($urandom % 3) == 0;
        pf = ($urandom % 4) == 0;
      end
      2: begin
        e  = (rel % 2) == 1;
        pf = (rel >= 4) && (rel < 7);
      end
      default: ;
    endcase
    fifo_in_empty = e || (in_q.size() == 0);
    fifo_in_dout  = (in_q.size() != 0) ? in_q[0] : '0;
    hdr_full = hf;
    pix_full = pf;
    if (noisy && m_active) begin
      start   = 1'($urandom % 2);
      width   = CW'($urandom);
      height  = CW'($urandom);
      hdr_len = HW'($urandom);
    end else begin
      start = 1'b0;
    end
  endtask

  task automatic check_cycle();
    bit hdr_ph, pix_ph, exp_h, exp_p;
    int k;
    hdr_ph = m_active && (m_n < m_hl);
    pix_ph = m_active && (m_n >= m_hl);
    exp_h  = hdr_ph && !fifo_in_empty && !hdr_full;
    exp_p  = pix_ph && !fifo_in_empty && !pix_full;
    k = m_n - m_hl;
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_done_now));
    check("hdr_wr_en", 32'(hdr_wr_en), 32'(exp_h));
    check("pix_wr_en", 32'(pix_wr_en), 32'(exp_p));
    check("fifo_in_rd_en", 32'(fifo_in_rd_en), 32'(exp_h || exp_p));
    if (pix_ph) begin
      check("col", 32'(col), k % m_w);
      check("row", 32'(row), k / m_w);
      check("pix_last", 32'(pix_last), 32'(k == m_w * m_h - 1));
    end else begin
      check("col_hold", 32'(col), m_col_hold);
      check("row_hold", 32'(row), m_row_hold);
      check("pix_last_idle", 32'(pix_last), 0);
    end
    if (exp_h) check("hdr_din", 32'(hdr_din), 32'(in_q[0]));
    if (exp_p) check("pix_din", 32'(pix_din), 32'(in_q[0]));
    m_xfer = exp_h || exp_p;
    cnt_hdr  += (hdr_wr_en === 1'b1) ? 1 : 0;
    cnt_pix  += (pix_wr_en === 1'b1) ? 1 : 0;
    cnt_done += (done === 1'b1) ? 1 : 0;
    cnt_rd   += (fifo_in_rd_en === 1'b1) ? 1 : 0;
  endtask

  task automatic model_edge();
    m_done_now = 0;
    if (m_xfer) begin
      void'(in_q.pop_front());
      m_n++;
      if (m_n == m_total) begin
        m_active   = 0;
        m_done_now = 1;
        m_col_hold = m_w - 1;
        m_row_hold = m_h - 1;
      end
    end
    m_xfer = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_en", 32'(fifo_in_rd_en), 0);
    check("rst_hdr_wr", 32'(hdr_wr_en), 0);
    check("rst_pix_wr", 32'(pix_wr_en), 0);
    check("rst_pix_last", 32'(pix_last), 0);
    check("rst_col", 32'(col), 0);
    check("rst_row", 32'(row), 0);
    @(posedge clock);
    #1;
    check("rst_hold_done", 32'(done), 0);
    check("rst_hold_busy", 32'(busy), 0);
    @(negedge clock);
    reset = 1'b1;
    m_active = 0; m_done_now = 0; m_xfer = 0;
    m_col_hold = 0; m_row_hold = 0;
    in_q.delete();
  endtask

  task automatic run_frame(input int hl, input int w, input int h, input int smode,
                           input bit nz, input int rst_at, input bit b2b,
                           input int e_hdr, input int e_pix, input int e_done);
    bit seen_done, aborted;
    seen_done = 0; aborted = 0;
    in_q.delete();
    for (int i = 0; i < hl + w * h; i++) in_q.push_back(DW'($urandom));
    cnt_hdr = 0; cnt_pix = 0; cnt_done = 0; cnt_rd = 0;
    stall_mode = smode;
    noisy = nz;
    @(negedge clock);
    start = 1'b1; width = CW'(w); height = CW'(h); hdr_len = HW'(hl);
    fifo_in_empty = (in_q.size() == 0);
    fifo_in_dout  = (in_q.size() != 0) ? in_q[0] : '0;
    hdr_full = 1'b0; pix_full = 1'b0;
    #1 check_cycle();
    @(posedge clock);
    model_edge();
    m_hl = hl; m_w = w; m_h = h; m_n = 0; m_total = hl + w * h;
    m_col_hold = 0; m_row_hold = 0;
    if (w == 0 || h == 0) m_done_now = 1;
    else m_active = 1;
    for (int rel = 0; rel < 2000; rel++) begin
      @(negedge clock);
      drive_cycle(rel);
      if (rst_at >= 0 && m_active && m_n == hl + rst_at) begin
        do_reset();
        aborted = 1;
        break;
      end
      #1 check_cycle();
      seen_done = m_done_now;
      @(posedge clock);
      model_edge();
      if (seen_done) break;
    end
    if (!seen_done && !aborted) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout: no done within 2000 cycles (hl=%0d w=%0d h=%0d)", hl, w, h);
    end
    if (!b2b) begin
      @(negedge clock);
      start = 1'b0;
      fifo_in_empty = 1'b1;
      #1 check_cycle();
      @(posedge clock);
      model_edge();
    end
    check("frame_hdr_writes", cnt_hdr, e_hdr);
    check("frame_pix_writes", cnt_pix, e_pix);
    check("frame_done_pulses", cnt_done, e_done);
    check("frame_pops", cnt_rd, e_hdr + e_pix);
    $display("frame hl=%0d w=%0d h=%0d mode=%0d noisy=%0d rst_at=%0d: hdr=%0d pix=%0d done=%0d",
             hl, w, h, smode, nz, rst_at, cnt_hdr, cnt_pix, cnt_done);
  endtask

  typedef struct {
    int hl; int w; int h; int smode; bit noisy; int rst_at; bit b2b;
    int e_hdr; int e_pix; int e_done;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{3, 2, 2, 0, 1'b0, -1, 1'b0, 3, 4, 1};
    vecs[1] = '{3, 2, 2, 2, 1'b0, -1, 1'b0, 3, 4, 1};
    vecs[2] = '{0, 3, 1, 0, 1'b0, -1, 1'b0, 0, 3, 1};
    vecs[3] = '{4, 0, 5, 0, 1'b0, -1, 1'b0, 0, 0, 1};
    vecs[4] = '{2, 3, 2, 0, 1'b1, -1, 1'b0, 2, 6, 1};
    vecs[5] = '{3, 2, 2, 0, 1'b0,  2, 1'b0, 3, 2, 0};
    vecs[6] = '{3, 2, 2, 0, 1'b0, -1, 1'b1, 3, 4, 1};
    vecs[7] = '{1, 4, 3, 1, 1'b1, -1, 1'b0, 1, 12, 1};
    vecs[8] = '{5, 1, 1, 1, 1'b0, -1, 1'b0, 5, 1, 1};
    vecs[9] = '{0, 2, 0, 0, 1'b0, -1, 1'b0, 0, 0, 1};

    #2;
    check("init_busy", 32'(busy), 0);
    check("init_done", 32'(done), 0);
    check("init_rd_en", 32'(fifo_in_rd_en), 0);
    check("init_col", 32'(col), 0);
    check("init_row", 32'(row), 0);
    check("init_pix_last", 32'(pix_last), 0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_frame(vecs[i].hl, vecs[i].w, vecs[i].h, vecs[i].smode, vecs[i].noisy,
                vecs[i].rst_at, vecs[i].b2b, vecs[i].e_hdr, vecs[i].e_pix, vecs[i].e_done);
    end

    for (int i = 0; i < 8; i++) begin
      int hl, w, h;
      hl = int'($urandom_range(0, 4));
      w  = int'($urandom_range(0, 5));
      h  = int'($urandom_range(0, 4));
      run_frame(hl, w, h, 1, 1'($urandom % 2), -1, 1'b0,
                (w == 0 || h == 0) ? 0 : hl, w * h, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
